channel_fir_emu: RTL and testbench

Clocked, sampled-data successor to the PWL channel model: an N-tap programmable FIR channel response followed by a programmable bulk delay. It sits between the TX serializer model and the RX front end in link-level benches and in FPGA emulation. Coefficients and delay are runtime-configurable, so one build covers many measured channels.

---
 rtl/channel_fir_emu.sv | 160 ++++++++++++++++
 tb/tb_channel_fir_emu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/channel_fir_emu.sv
// Sampled-data channel model: N-tap programmable FIR, rounding/saturation, then a
// runtime-programmable bulk delay. Optional macro CHANNEL_NOISE_EN adds LFSR dither.
module channel_fir_emu #(
  parameter int unsigned N_TAPS    = 8,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned COEF_W    = 10,
  parameter int unsigned COEF_FRAC = 8,
  parameter int unsigned MAX_DELAY = 16,
  localparam int unsigned DLY_W    = $clog2(MAX_DELAY + 1),
  localparam int unsigned ADDR_W   = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  input  logic [DLY_W-1:0]         cfg_delay,
`ifdef CHANNEL_NOISE_EN
  input  logic                     noise_on,
`endif
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     dly_busy
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  // One guard bit above the nominal accumulator width absorbs the rounding offset.
  localparam int unsigned ACC_W  = PROD_W + $clog2(N_TAPS) + 1;
  localparam int unsigned PTR_W  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  localparam logic signed [COEF_W-1:0] CoefOne = COEF_W'(1) << COEF_FRAC;
  localparam logic signed [ACC_W-1:0]  Half    = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0]  MaxVal  = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  MinVal  = ~MaxVal;

  logic signed [DATA_W-1:0] x_q    [N_TAPS];
  logic signed [DATA_W-1:0] x_d    [N_TAPS];
  logic signed [COEF_W-1:0] coef_q [N_TAPS];
  logic signed [COEF_W-1:0] coef_d [N_TAPS];
  logic signed [PROD_W-1:0] p_q    [N_TAPS];
  logic signed [PROD_W-1:0] p_d    [N_TAPS];
  logic                     s1_valid_q, s2_valid_q;
  logic signed [DATA_W-1:0] s2_data_q, s2_data_d;

  logic [MAX_DELAY-1:0]     ring_valid_q, ring_valid_d;
  logic signed [DATA_W-1:0] ring_data_q [MAX_DELAY];
  logic signed [DATA_W-1:0] ring_data_d [MAX_DELAY];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr;
  logic [DLY_W-1:0]         dly_q, dly_d, busy_q, busy_d, dly_new;
  logic                     dly_chg;

  logic signed [ACC_W-1:0]  acc, res;
  logic signed [ACC_W-1:0]  noise;

`ifdef CHANNEL_NOISE_EN
  logic [15:0]              lfsr_q, lfsr_d;
  logic signed [3:0]        noise4;

  always_comb begin
    lfsr_d = lfsr_q;
    if (s1_valid_q) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    noise4 = $signed({1'b0, lfsr_q[2:0]}) - 4'sd4;
    noise  = noise_on ? ACC_W'(noise4) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign noise = '0;
`endif

  // Tap line, coefficient file and stage 1 products; products use pre-write coefficients.
  always_comb begin
    x_d    = x_q;
    p_d    = p_q;
    coef_d = coef_q;
    if (in_valid) begin
      x_d[0] = in_data;
      for (int k = 1; k < int'(N_TAPS); k++) x_d[k] = x_q[k-1];
      for (int k = 0; k < int'(N_TAPS); k++) p_d[k] = PROD_W'(x_d[k]) * PROD_W'(coef_q[k]);
    end
    if (cfg_we && (32'(cfg_addr) < N_TAPS)) coef_d[cfg_addr] = cfg_data;
  end

  // Stage 2: sum, round half up, optional dither, saturate.
  always_comb begin
    acc = '0;
    for (int k = 0; k < int'(N_TAPS); k++) acc = acc + ACC_W'(p_q[k]);
    res = ((acc + Half) >>> COEF_FRAC) + noise;
    s2_data_d = s2_data_q;
    if (s1_valid_q) begin
      if (res > MaxVal)      s2_data_d = MaxVal[DATA_W-1:0];
      else if (res < MinVal) s2_data_d = MinVal[DATA_W-1:0];
      else                   s2_data_d = res[DATA_W-1:0];
    end
  end

  // Bulk delay: a changed setting flushes the ring and starts a refill countdown.
  always_comb begin
    int rd;
    dly_new  = (cfg_delay > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : cfg_delay;
    dly_chg  = (dly_new != dly_q);
    dly_d    = dly_new;
    busy_d   = dly_chg ? dly_new : ((busy_q != '0) ? busy_q - DLY_W'(1) : '0);
    wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + PTR_W'(1);

    ring_valid_d           = dly_chg ? '0 : ring_valid_q;
    ring_valid_d[wr_ptr_q] = s2_valid_q && !dly_chg;
    ring_data_d            = ring_data_q;
    ring_data_d[wr_ptr_q]  = s2_data_q;

    rd = int'(wr_ptr_q) - int'(dly_q);
    if (rd < 0) rd = rd + int'(MAX_DELAY);
    rd_ptr = PTR_W'(rd);

    if (dly_q == '0) begin
      out_valid = s2_valid_q;
      out_data  = s2_valid_q ? s2_data_q : '0;
    end else begin
      out_valid = ring_valid_q[rd_ptr];
      out_data  = ring_valid_q[rd_ptr] ? ring_data_q[rd_ptr] : '0;
    end
    dly_busy = (busy_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N_TAPS); k++) begin
        x_q[k]    <= '0;
        p_q[k]    <= '0;
        coef_q[k] <= (k == 0) ? CoefOne : '0;
      end
      for (int i = 0; i < int'(MAX_DELAY); i++) ring_data_q[i] <= '0;
      ring_valid_q <= '0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      wr_ptr_q     <= '0;
      dly_q        <= '0;
      busy_q       <= '0;
    end else begin
      x_q          <= x_d;
      p_q          <= p_d;
      coef_q       <= coef_d;
      ring_data_q  <= ring_data_d;
      ring_valid_q <= ring_valid_d;
      s1_valid_q   <= in_valid;
      s2_valid_q   <= s1_valid_q;
      s2_data_q    <= s2_data_d;
      wr_ptr_q     <= wr_ptr_d;
      dly_q        <= dly_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_channel_fir_emu.sv
// Directed bench for channel_fir_emu: passthrough, impulse, rounding, delay, reset.
module tb_channel_fir_emu;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned COEF_W = 10;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DLY_W  = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic signed [COEF_W-1:0] cfg_data;
  logic [DLY_W-1:0]         cfg_delay;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     dly_busy;

  int errs   = 0;
  int checks = 0;
  int nb;
  int lat;

  channel_fir_emu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_delay (cfg_delay),
`ifdef CHANNEL_NOISE_EN
    .noise_on  (1'b0),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .dly_busy  (dly_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d);
    in_valid = v;
    in_data  = DATA_W'(d);
    tick();
  endtask

  task automatic wcoef(input int a, input int val);
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_addr = ADDR_W'(a);
    cfg_data = COEF_W'(val);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic outchk(input string tag, input int d);
    chk({tag, "_valid"}, {31'b0, out_valid}, 1);
    chk({tag, "_data"}, $signed(out_data), d);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; cfg_delay = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_dly_busy", {31'b0, dly_busy}, 0);
    rst = 1'b0;
    tick();

    // Passthrough, D=0
    drive(1'b1, 100);
    chk("pt_lat", {31'b0, out_valid}, 0);
    drive(1'b1, -37);
    outchk("pt0", 100);
    drive(1'b1, 2047);
    outchk("pt1", -37);
    drive(1'b0, 0);
    outchk("pt2", 2047);
    tick();
    chk("pt_idle", {31'b0, out_valid}, 0);

    // Impulse response {256,128,-64}
    wcoef(1, 128);
    wcoef(2, -64);
    repeat (8) drive(1'b1, 0);
    drive(1'b0, 0);
    drive(1'b0, 0);
    drive(1'b1, 512);
    drive(1'b1, 0);
    outchk("imp0", 512);
    drive(1'b1, 0);
    outchk("imp1", 256);
    drive(1'b1, 0);
    outchk("imp2", -128);
    drive(1'b0, 0);
    outchk("imp3", 0);
    tick();
    chk("imp_idle", {31'b0, out_valid}, 0);

    // Rounding and saturation
    wcoef(1, 0);
    wcoef(2, 0);
    wcoef(0, 384);
    drive(1'b1, 2000);
    drive(1'b1, -2048);
    outchk("sat_pos", 2047);
    drive(1'b0, 0);
    outchk("sat_neg", -2048);
    wcoef(0, 1);
    drive(1'b1, 128);
    drive(1'b0, 0);
    outchk("round_half", 1);

    // Coefficient write on the same edge as a sample
    wcoef(0, 256);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = 10'sd511;
    drive(1'b1, 10);
    cfg_we = 1'b0;
    drive(1'b1, 10);
    outchk("cw_old", 10);
    drive(1'b0, 0);
    outchk("cw_new", 20);
    wcoef(0, 256);
    tick();

    // Bulk delay of 5
    cfg_delay = 5'd5;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("d5_busy", {31'b0, dly_busy}, 1);
      chk("d5_quiet", {31'b0, out_valid}, 0);
      tick();
    end
    chk("d5_busy_done", {31'b0, dly_busy}, 0);
    drive(1'b1, 300);
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk("d5_valid_at", {31'b0, out_valid}, (k == 7) ? 1 : 0);
      if (k == 7) chk("d5_data", $signed(out_data), 300);
      tick();
    end

    // Delay request above the maximum clamps to 16
    cfg_delay = 5'd20;
    tick();
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (dly_busy) nb++;
      tick();
    end
    chk("clamp_busy_cycles", nb, 16);
    drive(1'b1, 50);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("clamp_latency", lat, 18);
    chk("clamp_data", $signed(out_data), 50);
    chk("clamp_no_retrigger", {31'b0, dly_busy}, 0);

    // Reset with D=4 and six samples in flight
    cfg_delay = 5'd4;
    repeat (6) tick();
    wcoef(0, 128);
    wcoef(1, 64);
    for (int i = 0; i < 6; i++) drive(1'b1, 11 + i);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    cfg_delay = '0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_data", $signed(out_data), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("post_rst_quiet", {31'b0, out_valid}, 0);
      tick();
    end
    drive(1'b1, 7);
    drive(1'b1, 7);
    outchk("post_rst0", 7);
    drive(1'b0, 0);
    outchk("post_rst1", 7);
    tick();
    chk("post_rst_idle", {31'b0, out_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
